// File: rtl/weight_mux_accum.sv
// rtl/weight_mux_accum.sv - time-multiplexed signed weight-select accumulator
//
// Computes field_out = sum_i c_i, where c_i = (z[i]^o[i]) ? (z[i] ? W[i] : -W[i]) : 0,
// consuming LANES entries per cycle into a single accumulator.
//
// Optional feature macro: WMUX_ACC_SAT_EN (saturating accumulator plus sticky sat_flag).
// With the macro undefined the accumulator wraps and sat_flag stays 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a new accumulation (sampled in IDLE only)
//   z_out      spin-state vector A (captured at start)
//   o_out      spin-state vector B (captured at start)
//   W          signed weights, entry i at W[i*W_WIDTH +: W_WIDTH]; held stable by the caller
//   busy       high while accumulating
//   done       one-cycle pulse, field_out valid from this cycle
//   field_out  signed accumulated sum, held until the next result
//   sat_flag   sticky per run: accumulator clipped

module weight_mux_accum #(
    parameter int OUTPUTS   = 16,
    parameter int LANES     = 4,
    parameter int W_WIDTH   = 32,
    parameter int ACC_WIDTH = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [OUTPUTS-1:0]           z_out,
    input  logic [OUTPUTS-1:0]           o_out,
    input  logic [OUTPUTS*W_WIDTH-1:0]   W,
    output logic                         busy,
    output logic                         done,
    output logic [ACC_WIDTH-1:0]         field_out,
    output logic                         sat_flag
);

    localparam int CHUNKS = (OUTPUTS + LANES - 1) / LANES;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    // Chunk table is padded to a power-of-two depth so idx indexes it at its natural width.
    localparam int DEPTH  = 1 << IDX_W;
`ifdef WMUX_ACC_SAT_EN
    localparam int LS_W   = ACC_WIDTH + 1;
`else
    localparam int LS_W   = ACC_WIDTH;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                 state, state_next;
    logic [OUTPUTS-1:0]     z_q, o_q;
    logic [ACC_WIDTH-1:0]   acc, acc_next;
    logic [IDX_W-1:0]       idx;
    logic                   clip;

    // Padding lanes carry z=o=0 and therefore contribute nothing.
    logic [DEPTH-1:0][LANES-1:0]              z_ch, o_ch;
    logic [DEPTH-1:0][LANES-1:0][W_WIDTH-1:0] w_ch;

    assign z_ch = (DEPTH*LANES)'(z_q);
    assign o_ch = (DEPTH*LANES)'(o_q);
    assign w_ch = (DEPTH*LANES*W_WIDTH)'(W);

    logic [W_WIDTH:0]  w_ext, term;
    logic [LS_W-1:0]   lane_sum;

    // Negation at W_WIDTH+1 bits keeps -(most negative weight) representable.
    always_comb begin
        lane_sum = '0;
        w_ext    = '0;
        term     = '0;
        for (int l = 0; l < LANES; l++) begin
            w_ext = {w_ch[idx][l][W_WIDTH-1], w_ch[idx][l]};
            if (z_ch[idx][l] ^ o_ch[idx][l])
                term = z_ch[idx][l] ? w_ext : -w_ext;
            else
                term = '0;
            lane_sum = lane_sum + {{(LS_W-W_WIDTH-1){term[W_WIDTH]}}, term};
        end
    end

`ifdef WMUX_ACC_SAT_EN
    logic [ACC_WIDTH+1:0] sum_full;

    // Result fits ACC_WIDTH exactly when the top three bits agree.
    always_comb begin
        sum_full = {{2{acc[ACC_WIDTH-1]}}, acc} + {lane_sum[ACC_WIDTH], lane_sum};
        clip     = (sum_full[ACC_WIDTH+1] != sum_full[ACC_WIDTH-1]) ||
                   (sum_full[ACC_WIDTH]   != sum_full[ACC_WIDTH-1]);
        if (clip)
            acc_next = sum_full[ACC_WIDTH+1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            acc_next = sum_full[ACC_WIDTH-1:0];
    end
`else
    always_comb begin
        clip     = 1'b0;
        acc_next = acc + lane_sum;
    end
`endif

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_ACCUM;
            S_ACCUM: begin
                busy = 1'b1;
                if (idx == IDX_W'(CHUNKS-1)) state_next = S_DONE;
            end
            S_DONE:  begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            z_q       <= '0;
            o_q       <= '0;
            acc       <= '0;
            idx       <= '0;
            field_out <= '0;
            sat_flag  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: if (start) begin
                    z_q      <= z_out;
                    o_q      <= o_out;
                    acc      <= '0;
                    idx      <= '0;
                    sat_flag <= 1'b0;
                end
                S_ACCUM: begin
                    acc      <= acc_next;
                    idx      <= idx + 1'b1;
                    sat_flag <= sat_flag | clip;
                    // Publish on the way into DONE so the result is valid with the done pulse.
                    if (idx == IDX_W'(CHUNKS-1)) field_out <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_mux_accum.sv
// tb/tb_weight_mux_accum.sv - scoreboard bench for weight_mux_accum

module tb_weight_mux_accum;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   z = '0, o = '0;
    logic [191:0] w_bus = '0;
    logic [3:0]   start_v = '0;
    logic [3:0]   busy_v, done_v, sat_v;
    logic [39:0]  field_a, field_c, field_d;
    logic [33:0]  field_b;

    always #5 clk = ~clk;

    weight_mux_accum #(.OUTPUTS(6), .LANES(4), .W_WIDTH(32), .ACC_WIDTH(40)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .z_out(z), .o_out(o), .W(w_bus),
        .busy(busy_v[0]), .done(done_v[0]), .field_out(field_a), .sat_flag(sat_v[0]));
    weight_mux_accum #(.OUTPUTS(6), .LANES(4), .W_WIDTH(32), .ACC_WIDTH(34)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .z_out(z), .o_out(o), .W(w_bus),
        .busy(busy_v[1]), .done(done_v[1]), .field_out(field_b), .sat_flag(sat_v[1]));
    weight_mux_accum #(.OUTPUTS(6), .LANES(1), .W_WIDTH(32), .ACC_WIDTH(40)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .z_out(z), .o_out(o), .W(w_bus),
        .busy(busy_v[2]), .done(done_v[2]), .field_out(field_c), .sat_flag(sat_v[2]));
    weight_mux_accum #(.OUTPUTS(6), .LANES(6), .W_WIDTH(32), .ACC_WIDTH(40)) u_d (
        .clk(clk), .rst(rst), .start(start_v[3]), .z_out(z), .o_out(o), .W(w_bus),
        .busy(busy_v[3]), .done(done_v[3]), .field_out(field_d), .sat_flag(sat_v[3]));

    typedef struct {
        longint field;
        bit     sat;
        int     lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic longint get_field(input int u);
        case (u)
            0:       return longint'($signed(field_a));
            1:       return longint'($signed(field_b));
            2:       return longint'($signed(field_c));
            default: return longint'($signed(field_d));
        endcase
    endfunction

    function automatic longint wrapv(input longint v, input int width);
        longint m;
        m = v & ((64'sd1 <<< width) - 1);
        if (m[width-1]) m = m - (64'sd1 <<< width);
        return m;
    endfunction

    // Reference: exact signed arithmetic per chunk, then clip or wrap to the accumulator width.
    function automatic longint model(input int lanes, input int accw, input logic [5:0] zz,
                                     input logic [5:0] oo, input logic [191:0] ww, output bit sat);
        longint acc, s, wv, mx, mn;
        int e;
        acc = 0;
        sat = 1'b0;
        mx  = (64'sd1 <<< (accw-1)) - 1;
        mn  = -(64'sd1 <<< (accw-1));
        for (int c = 0; c * lanes < 6; c++) begin
            s = 0;
            for (int l = 0; l < lanes; l++) begin
                e = c * lanes + l;
                if (e < 6 && zz[e] != oo[e]) begin
                    wv = longint'($signed(ww[e*32 +: 32]));
                    s  = zz[e] ? s + wv : s - wv;
                end
            end
`ifdef WMUX_ACC_SAT_EN
            acc = acc + s;
            if (acc > mx) begin acc = mx; sat = 1'b1; end
            if (acc < mn) begin acc = mn; sat = 1'b1; end
`else
            acc = wrapv(acc + s, accw);
`endif
        end
        return acc;
    endfunction

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic set_w(input int i, input logic [31:0] v);
        w_bus[i*32 +: 32] = v;
    endtask

    task automatic push_exp(input int lanes, input int accw);
        exp_t e;
        bit   s;
        e.field = model(lanes, accw, z, o, w_bus, s);
        e.sat   = s;
        e.lat   = (6 + lanes - 1) / lanes + 1;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done on unit u, then pops and compares; k counts edges since start drive.
    task automatic finish_run(input int u, input string tag, inout int k, output longint got);
        exp_t e;
        while (!done_v[u] && k < 60) begin
            @(posedge clk); #1;
            start_v[u] = 1'b0;
            k++;
        end
        e   = sb.pop_front();
        got = get_field(u);
        check({tag, "_done"}, longint'(done_v[u]), 1);
        check({tag, "_lat"}, k, e.lat);
        check({tag, "_field"}, got, e.field);
        check({tag, "_sat"}, longint'(sat_v[u]), longint'(e.sat));
    endtask

    task automatic run(input int u, input int lanes, input int accw, input string tag,
                       output longint got);
        int k;
        push_exp(lanes, accw);
        start_v[u] = 1'b1;
        k = 0;
        @(posedge clk); #1;
        start_v[u] = 1'b0;
        k = 1;
        if (lanes < 6) check({tag, "_busy"}, longint'(busy_v[u]), 1);
        finish_run(u, tag, k, got);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, longint'(done_v[u]), 0);
    endtask

    initial begin : main
        longint got;
        int     k;
        int     seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", longint'(busy_v[0]), 0);
        check("rst_done", longint'(done_v[0]), 0);
        check("rst_field", get_field(0), 0);
        check("rst_sat", longint'(sat_v[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) set_w(i, 32'(i + 1));
        z = 6'b111111; o = 6'b000000;
        run(0, 4, 40, "t1", got);
        check("t1_const", got, 21);

        z = 6'b000000; o = 6'b010101;
        run(0, 4, 40, "t2a", got);
        check("t2a_const", got, -9);
        z = 6'b111111; o = 6'b111111;
        run(0, 4, 40, "t2b", got);
        check("t2b_const", got, 0);

        set_w(0, 32'h8000_0000);
        z = 6'b000001; o = 6'b000000;
        run(0, 4, 40, "t3a", got);
        check("t3a_const", got, -64'sd2147483648);
        z = 6'b000000; o = 6'b000001;
        run(0, 4, 40, "t3b", got);
        check("t3b_const", got, 64'sd2147483648);

        for (int i = 0; i < 6; i++) set_w(i, 32'h7FFF_FFFF);
        z = 6'b111111; o = 6'b000000;
        run(1, 4, 34, "t4", got);
`ifdef WMUX_ACC_SAT_EN
        check("t4_const", got, 64'sd8589934591);
        check("t4_sat_const", longint'(sat_v[1]), 1);
`else
        check("t4_const", got, -64'sd4294967302);
        check("t4_sat_const", longint'(sat_v[1]), 0);
`endif
        for (int i = 0; i < 6; i++) set_w(i, 32'(i + 1));
        run(1, 4, 34, "t4_clear", got);
        check("t4_clear_sat", longint'(sat_v[1]), 0);

        // start retriggered one cycle into ACCUM with different z must not disturb the run
        z = 6'b111111; o = 6'b000000;
        push_exp(4, 40);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        z = 6'b000011;
        start_v[0] = 1'b1;
        k = 2;
        finish_run(0, "t5_retrig", k, got);
        check("t5_retrig_const", got, 21);
        // start held during DONE is ignored
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check("t5_done_start_busy", longint'(busy_v[0]), 0);
        check("t5_done_start_done", longint'(done_v[0]), 0);
        @(posedge clk); #1;
        check("t5_done_start_idle", longint'(busy_v[0]), 0);

        // rst mid-ACCUM aborts with no done pulse
        z = 6'b111111;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_rst_busy", longint'(busy_v[0]), 0);
        check("t5_rst_field", get_field(0), 0);
        #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_v[0]) seen++;
        end
        check("t5_rst_no_done", seen, 0);

        for (int it = 0; it < 8; it++) begin
            z = 6'($urandom);
            o = 6'($urandom);
            for (int i = 0; i < 6; i++) set_w(i, $urandom);
            run(2, 1, 40, $sformatf("t6_l1_%0d", it), got);
            run(3, 6, 40, $sformatf("t6_l6_%0d", it), got);
            run(0, 4, 40, $sformatf("t6_l4_%0d", it), got);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
